// File: rtl/oldland_mem_arbiter.sv
// Two-way memory bus arbiter between the instruction and data caches.
// A grant is held across a burst and is released after MAX_BURST beats so the other side gets a turn.
module oldland_mem_arbiter #(
  parameter int MAX_BURST = 8,
  parameter int BEAT_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_access,
  input  logic [29:0] i_addr,
  output logic [31:0] i_data,
  output logic        i_ack,
  output logic        i_error,
  input  logic        d_access,
  input  logic [29:0] d_addr,
  input  logic [31:0] d_wr_val,
  input  logic        d_wr_en,
  input  logic [3:0]  d_bytesel,
  output logic [31:0] d_data,
  output logic        d_ack,
  output logic        d_error,
  output logic        m_access,
  output logic [29:0] m_addr,
  output logic [31:0] m_wr_val,
  output logic        m_wr_en,
  output logic [3:0]  m_bytesel,
  input  logic [31:0] m_data,
  input  logic        m_ack,
  input  logic        m_error,
  output logic [1:0]  owner
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(MAX_BURST - 1);

  state_t               state, state_nxt;
  logic                 last_d, last_d_nxt;   // 1: dcache held the bus most recently
  logic [BEAT_BITS-1:0] beat_cnt, beat_cnt_nxt;

  logic i_granted, d_granted, own_access;

  assign i_granted  = (state == GRANT_I);
  assign d_granted  = (state == GRANT_D);
  assign own_access = (i_granted & i_access) | (d_granted & d_access);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      last_d   <= 1'b0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      last_d   <= last_d_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    last_d_nxt   = last_d;
    beat_cnt_nxt = beat_cnt;
    case (state)
      IDLE: begin
        // On a tie the side that did not own the bus last goes first.
        if (i_access && d_access)
          state_nxt = last_d ? GRANT_I : GRANT_D;
        else if (d_access)
          state_nxt = GRANT_D;
        else if (i_access)
          state_nxt = GRANT_I;
      end
      GRANT_I, GRANT_D: begin
        if ((m_ack && (beat_cnt == LAST_BEAT)) || !own_access) begin
          state_nxt    = IDLE;
          beat_cnt_nxt = '0;
          last_d_nxt   = d_granted;
        end else if (m_ack) begin
          beat_cnt_nxt = beat_cnt + BEAT_BITS'(1);
        end
      end
      default: begin
        state_nxt    = IDLE;
        beat_cnt_nxt = '0;
      end
    endcase
  end

  // Memory-side mux: only the owner's request reaches the bus.
  always_comb begin
    m_access  = 1'b0;
    m_addr    = '0;
    m_wr_val  = '0;
    m_wr_en   = 1'b0;
    m_bytesel = '0;
    if (i_granted) begin
      m_access  = i_access;
      m_addr    = i_addr;
      m_bytesel = 4'hf;
    end else if (d_granted) begin
      m_access  = d_access;
      m_addr    = d_addr;
      m_wr_val  = d_wr_val;
      m_wr_en   = d_wr_en;
      m_bytesel = d_bytesel;
    end
  end

  assign i_ack   = m_ack & i_granted;
  assign i_error = m_error & m_ack & i_granted;
  assign i_data  = i_granted ? m_data : 32'h0;

  assign d_ack   = m_ack & d_granted;
  assign d_error = m_error & m_ack & d_granted;
  assign d_data  = d_granted ? m_data : 32'h0;

  assign owner = {d_granted, i_granted};

endmodule

// File: tb/tb_oldland_mem_arbiter.sv
// Directed bench for oldland_mem_arbiter: reset, single read, tie-break, forced burst release,
// write passthrough with error routing and reset in the middle of a burst.
module tb_oldland_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_access;
  logic [29:0] i_addr;
  logic [31:0] i_data;
  logic        i_ack, i_error;
  logic        d_access;
  logic [29:0] d_addr;
  logic [31:0] d_wr_val;
  logic        d_wr_en;
  logic [3:0]  d_bytesel;
  logic [31:0] d_data;
  logic        d_ack, d_error;
  logic        m_access;
  logic [29:0] m_addr;
  logic [31:0] m_wr_val;
  logic        m_wr_en;
  logic [3:0]  m_bytesel;
  logic [31:0] m_data;
  logic        m_ack, m_error;
  logic [1:0]  owner;

  int n_tests = 0;
  int n_fail  = 0;
  int d_beats = 0;

  always #5 clk = ~clk;

  oldland_mem_arbiter #(.MAX_BURST(8), .BEAT_BITS(4)) dut (
    .clk(clk), .rst(rst),
    .i_access(i_access), .i_addr(i_addr), .i_data(i_data), .i_ack(i_ack), .i_error(i_error),
    .d_access(d_access), .d_addr(d_addr), .d_wr_val(d_wr_val), .d_wr_en(d_wr_en),
    .d_bytesel(d_bytesel), .d_data(d_data), .d_ack(d_ack), .d_error(d_error),
    .m_access(m_access), .m_addr(m_addr), .m_wr_val(m_wr_val), .m_wr_en(m_wr_en),
    .m_bytesel(m_bytesel), .m_data(m_data), .m_ack(m_ack), .m_error(m_error),
    .owner(owner)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next n rising edges; inputs are then driven away from the edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b0;
    i_access = 0; i_addr = '0;
    d_access = 0; d_addr = '0; d_wr_val = '0; d_wr_en = 0; d_bytesel = '0;
    m_data = '0; m_ack = 0; m_error = 0;

    // Reset state
    #1;
    chk("rst_owner", 32'(owner), 32'h0);
    chk("rst_m_access", 32'(m_access), 32'h0);
    chk("rst_i_ack", 32'(i_ack), 32'h0);
    chk("rst_d_ack", 32'(d_ack), 32'h0);
    cyc(1);
    rst = 1'b1;
    cyc(2);
    #1;
    chk("idle_owner", 32'(owner), 32'h0);
    chk("idle_m_access", 32'(m_access), 32'h0);

    // Single icache read with ack on the third granted cycle
    cyc(1);
    i_access = 1; i_addr = 30'h100;
    #1;
    chk("rd_req_cycle_m_access", 32'(m_access), 32'h0);
    cyc(1);
    #1;
    chk("rd_m_access", 32'(m_access), 32'h1);
    chk("rd_owner", 32'(owner), 32'h1);
    chk("rd_m_addr", 32'(m_addr), 32'h100);
    chk("rd_m_bytesel", 32'(m_bytesel), 32'hf);
    chk("rd_m_wr_en", 32'(m_wr_en), 32'h0);
    cyc(1);
    #1;
    chk("rd_wait_owner", 32'(owner), 32'h1);
    cyc(1);
    m_ack = 1; m_data = 32'hDEADBEEF;
    #1;
    chk("rd_i_ack", 32'(i_ack), 32'h1);
    chk("rd_i_data", i_data, 32'hDEADBEEF);
    chk("rd_d_ack", 32'(d_ack), 32'h0);
    chk("rd_d_data", d_data, 32'h0);
    cyc(1);
    m_ack = 0; i_access = 0;
    #1;
    chk("rd_drop_m_access", 32'(m_access), 32'h0);
    cyc(1);
    #1;
    chk("rd_release_owner", 32'(owner), 32'h0);

    // Simultaneous requests right after reset: dcache first
    cyc(1);
    rst = 1'b0;
    #1;
    rst = 1'b1;
    i_access = 1; i_addr = 30'h300;
    d_access = 1; d_addr = 30'h200;
    cyc(1);
    #1;
    chk("tie_owner_d", 32'(owner), 32'h2);
    chk("tie_m_addr_d", 32'(m_addr), 32'h200);
    m_ack = 1;
    #1;
    chk("tie_d_ack", 32'(d_ack), 32'h1);
    chk("tie_i_ack_blocked", 32'(i_ack), 32'h0);
    cyc(1);
    m_ack = 0; d_access = 0;
    cyc(1);
    #1;
    chk("tie_gap_owner", 32'(owner), 32'h0);
    cyc(1);
    #1;
    chk("tie_owner_i", 32'(owner), 32'h1);
    chk("tie_m_addr_i", 32'(m_addr), 32'h300);
    m_ack = 1;
    #1;
    chk("tie_i_ack", 32'(i_ack), 32'h1);
    cyc(1);
    m_ack = 0; i_access = 0;
    cyc(1);

    // 12-beat dcache burst with icache waiting; forced release after 8 beats
    i_access = 1; i_addr = 30'h500;
    d_access = 1; d_addr = 30'h600;
    cyc(1);
    #1;
    chk("burst_owner_d", 32'(owner), 32'h2);
    for (int k = 0; k < 8; k++) begin
      m_ack = 1;
      #1;
      if (d_ack === 1'b1) d_beats++;
      if (k == 7) chk("burst_i_ack_quiet", 32'(i_ack), 32'h0);
      cyc(1);
    end
    m_ack = 1;
    #1;
    chk("burst_forced_release", 32'(owner), 32'h0);
    chk("idle_m_ack_d_ack", 32'(d_ack), 32'h0);
    chk("idle_m_ack_i_ack", 32'(i_ack), 32'h0);
    cyc(1);
    m_ack = 0;
    #1;
    chk("burst_owner_i", 32'(owner), 32'h1);
    m_ack = 1;
    #1;
    chk("burst_i_ack", 32'(i_ack), 32'h1);
    chk("burst_d_ack_blocked", 32'(d_ack), 32'h0);
    cyc(1);
    m_ack = 0; i_access = 0;
    cyc(1);
    #1;
    chk("burst_i_release", 32'(owner), 32'h0);
    cyc(1);
    #1;
    chk("burst_owner_d_resume", 32'(owner), 32'h2);
    for (int k = 0; k < 4; k++) begin
      m_ack = 1;
      #1;
      if (d_ack === 1'b1) d_beats++;
      cyc(1);
    end
    m_ack = 0; d_access = 0;
    chk("burst_total_d_beats", 32'(d_beats), 32'd12);
    cyc(1);
    #1;
    chk("burst_end_owner", 32'(owner), 32'h0);

    // dcache write passthrough and error routing
    d_access = 1; d_addr = 30'h40; d_wr_val = 32'h12345678; d_wr_en = 1; d_bytesel = 4'b0011;
    cyc(1);
    #1;
    chk("wr_m_addr", 32'(m_addr), 32'h40);
    chk("wr_m_wr_val", m_wr_val, 32'h12345678);
    chk("wr_m_wr_en", 32'(m_wr_en), 32'h1);
    chk("wr_m_bytesel", 32'(m_bytesel), 32'h3);
    m_ack = 1; m_error = 1;
    #1;
    chk("wr_d_error", 32'(d_error), 32'h1);
    chk("wr_i_error", 32'(i_error), 32'h0);
    chk("wr_d_ack", 32'(d_ack), 32'h1);
    cyc(1);
    m_ack = 0; m_error = 0; d_access = 0; d_wr_en = 0;
    cyc(1);

    // Reset in the middle of a dcache burst
    d_access = 1; d_addr = 30'h80;
    cyc(1);
    for (int k = 0; k < 2; k++) begin
      m_ack = 1;
      cyc(1);
    end
    m_ack = 0;
    #1;
    chk("mid_pre_m_access", 32'(m_access), 32'h1);
    rst = 1'b0;
    m_ack = 1;
    #1;
    chk("mid_rst_m_access", 32'(m_access), 32'h0);
    chk("mid_rst_owner", 32'(owner), 32'h0);
    chk("mid_rst_beat_cnt", 32'(dut.beat_cnt), 32'h0);
    chk("mid_rst_d_ack", 32'(d_ack), 32'h0);
    m_ack = 0; d_access = 0;
    cyc(1);
    rst = 1'b1;
    i_access = 1; d_access = 1;
    cyc(1);
    #1;
    chk("mid_tie_owner_d", 32'(owner), 32'h2);
    i_access = 0; d_access = 0;
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
